wb_uart16550_tx_seq: RTL and testbench

Hardware transmit sequencer upstream of the wb_uart16550 core. Acts as a Wishbone master that performs the UART initialisation sequence (divisor latch, line control, FIFO control) after reset, then accepts bytes on a valid/ready stream and writes them to the transmit holding register. It uses LSR polling and a FIFO credit counter for flow control. This lets hardware producers (test generators, boot loggers) drive the UART with no software.

---
 rtl/wb_uart16550_regs_pkg.sv | 36 +++
 rtl/wb_uart16550_tx_seq_wbm.sv | 64 ++++++
 rtl/wb_uart16550_tx_seq.sv | 157 +++++++++++++++
 tb/tb_wb_uart16550_tx_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_uart16550_regs_pkg.sv
// Shared 16550 register map, sequencer constants and state type.
// WB_UART16550_TX_SEQ_FIFO_CREDIT_EN selects a 16-byte credit per LSR poll instead of 1.
package wb_uart16550_regs_pkg;

  localparam logic [2:0] OFF_THR = 3'd0;
  localparam logic [2:0] OFF_DLL = 3'd0;
  localparam logic [2:0] OFF_IER = 3'd1;
  localparam logic [2:0] OFF_DLM = 3'd1;
  localparam logic [2:0] OFF_FCR = 3'd2;
  localparam logic [2:0] OFF_LCR = 3'd3;
  localparam logic [2:0] OFF_LSR = 3'd5;

  localparam int unsigned LSR_THRE_BIT    = 5;
  localparam int unsigned LCR_DLAB_BIT    = 7;
  localparam logic [7:0]  FCR_INIT        = 8'h07;
  localparam int unsigned UART_FIFO_DEPTH = 16;

  localparam int unsigned CREDIT_W = 5;
`ifdef WB_UART16550_TX_SEQ_FIFO_CREDIT_EN
  localparam int unsigned CREDIT_MAX = UART_FIFO_DEPTH;
`else
  localparam int unsigned CREDIT_MAX = 1;
`endif

  typedef enum logic [2:0] {
    INIT_LCR_DLAB,
    INIT_DLL,
    INIT_DLM,
    INIT_LCR,
    INIT_FCR,
    IDLE,
    WR_THR,
    RD_LSR
  } seq_state_e;

endpackage

// File: rtl/wb_uart16550_tx_seq_wbm.sv
// Single-access Wishbone classic master with byte-lane steering for 8-bit UART registers.
module wb_uart16550_tx_seq_wbm #(
  parameter logic [31:0] BASE = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_c,
  input  logic        req_we,
  input  logic [2:0]  req_off,
  input  logic [7:0]  req_wdat,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  input  logic        ack_i,
  output logic        done_c,
  output logic [7:0]  rdat_c
);

  // Launch only from idle so every access is followed by at least one cyc_o=0 cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      adr_o <= '0;
      dat_o <= '0;
      sel_o <= '0;
      cyc_o <= 1'b0;
      stb_o <= 1'b0;
      we_o  <= 1'b0;
    end else if (cyc_o) begin
      if (ack_i) begin
        adr_o <= '0;
        dat_o <= '0;
        sel_o <= '0;
        cyc_o <= 1'b0;
        stb_o <= 1'b0;
        we_o  <= 1'b0;
      end
    end else if (req_c) begin
      adr_o <= BASE + 32'(req_off);
      dat_o <= {4{req_wdat}};
      sel_o <= 4'(4'b0001 << req_off[1:0]);
      cyc_o <= 1'b1;
      stb_o <= 1'b1;
      we_o  <= req_we;
    end
  end

  assign done_c = cyc_o & ack_i;

  // BASE is 8-byte aligned, so the low address bits are the register lane.
  always_comb begin
    rdat_c = dat_i[7:0];
    case (adr_o[1:0])
      2'd0:    rdat_c = dat_i[7:0];
      2'd1:    rdat_c = dat_i[15:8];
      2'd2:    rdat_c = dat_i[23:16];
      default: rdat_c = dat_i[31:24];
    endcase
  end

endmodule

// File: rtl/wb_uart16550_tx_seq.sv
// Hardware UART transmit sequencer: init the 16550, then stream bytes into THR with LSR/credit flow control.
// Build macro WB_UART16550_TX_SEQ_FIFO_CREDIT_EN widens the per-poll credit to the 16-byte FIFO depth.
module wb_uart16550_tx_seq
  import wb_uart16550_regs_pkg::*;
#(
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter logic [15:0] DIVISOR = 16'd27,
  parameter logic [7:0]  LCR_VAL = 8'h03
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  input  logic        ack_i,
  input  logic [7:0]  s_dat,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        init_done,
  output logic        busy
);

  localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(CREDIT_MAX);
  localparam logic [7:0]          LCR_DLAB    = LCR_VAL | 8'h83;

  seq_state_e            state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [7:0]            byte_q;
  logic                  init_done_d, s_ready_d;
  logic                  req_c, we_c, hs_c, done_c;
  logic [2:0]            off_c;
  logic [7:0]            wdat_c, rdat_c;

  wb_uart16550_tx_seq_wbm #(
    .BASE (BASE)
  ) u_wbm (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .req_c    (req_c),
    .req_we   (we_c),
    .req_off  (off_c),
    .req_wdat (wdat_c),
    .adr_o    (adr_o),
    .dat_o    (dat_o),
    .dat_i    (dat_i),
    .sel_o    (sel_o),
    .cyc_o    (cyc_o),
    .stb_o    (stb_o),
    .we_o     (we_o),
    .ack_i    (ack_i),
    .done_c   (done_c),
    .rdat_c   (rdat_c)
  );

  assign busy = cyc_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= INIT_LCR_DLAB;
      credit_q  <= '0;
      byte_q    <= '0;
      init_done <= 1'b0;
      s_ready   <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      init_done <= init_done_d;
      s_ready   <= s_ready_d;
      if (hs_c) byte_q <= s_dat;
    end
  end

  // Next state, bus request and credit; a handshake launches the THR write in the same cycle.
  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    init_done_d = init_done;
    req_c       = 1'b0;
    we_c        = 1'b1;
    off_c       = OFF_THR;
    wdat_c      = '0;
    hs_c        = 1'b0;
    case (state_q)
      INIT_LCR_DLAB: begin
        req_c  = 1'b1;
        off_c  = OFF_LCR;
        wdat_c = LCR_DLAB;
        if (done_c) state_d = INIT_DLL;
      end
      INIT_DLL: begin
        req_c  = 1'b1;
        off_c  = OFF_DLL;
        wdat_c = DIVISOR[7:0];
        if (done_c) state_d = INIT_DLM;
      end
      INIT_DLM: begin
        req_c  = 1'b1;
        off_c  = OFF_DLM;
        wdat_c = DIVISOR[15:8];
        if (done_c) state_d = INIT_LCR;
      end
      INIT_LCR: begin
        req_c  = 1'b1;
        off_c  = OFF_LCR;
        wdat_c = LCR_VAL;
        if (done_c) state_d = INIT_FCR;
      end
      INIT_FCR: begin
        req_c  = 1'b1;
        off_c  = OFF_FCR;
        wdat_c = FCR_INIT;
        if (done_c) begin
          state_d     = IDLE;
          credit_d    = '0;
          init_done_d = 1'b1;
        end
      end
      IDLE: begin
        if (s_valid && s_ready) begin
          hs_c    = 1'b1;
          req_c   = 1'b1;
          off_c   = OFF_THR;
          wdat_c  = s_dat;
          state_d = WR_THR;
        end else if (s_valid && (credit_q == '0)) begin
          state_d = RD_LSR;
        end
      end
      WR_THR: begin
        req_c  = 1'b1;
        off_c  = OFF_THR;
        wdat_c = byte_q;
        if (done_c) begin
          credit_d = credit_q - CREDIT_W'(1);
          state_d  = IDLE;
        end
      end
      RD_LSR: begin
        req_c = 1'b1;
        we_c  = 1'b0;
        off_c = OFF_LSR;
        if (done_c) begin
          if (rdat_c[LSR_THRE_BIT]) credit_d = CREDIT_FULL;
          state_d = IDLE;
        end
      end
      default: state_d = INIT_LCR_DLAB;
    endcase
    // Ready only after a full cycle settled in IDLE, giving the N+3 byte cadence.
    s_ready_d = (state_q == IDLE) && (state_d == IDLE) && (credit_d != '0);
  end

endmodule

// File: tb/tb_wb_uart16550_tx_seq.sv
// Directed bench for wb_uart16550_tx_seq with a Wishbone slave model and access log.
module tb_wb_uart16550_tx_seq;

  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef WB_UART16550_TX_SEQ_FIFO_CREDIT_EN
  localparam int EXP_RD20 = 2;
`else
  localparam int EXP_RD20 = 20;
`endif

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic [31:0] adr_o, dat_o, dat_i;
  logic [3:0]  sel_o;
  logic        cyc_o, stb_o, we_o, ack_i;
  logic [7:0]  s_dat = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready, init_done, busy;

  int n_chk = 0;
  int n_fail = 0;
  int ack_dly = 0;
  int wcnt = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int lsr_start = 0;
  int lsr_len = 0;
  logic [7:0] lsr_seq [4];
  logic [7:0] lsr_default = 8'h60;
  logic [7:0] lsr_byte;

  logic [31:0] log_adr [$];
  logic [31:0] log_dat [$];
  logic [3:0]  log_sel [$];
  logic        log_we  [$];

  always #5 clk = ~clk;

  wb_uart16550_tx_seq #(
    .BASE    (BASE),
    .DIVISOR (16'h1234),
    .LCR_VAL (8'h03)
  ) dut (
    .clk_i     (clk),
    .rstn_i    (rstn_i),
    .adr_o     (adr_o),
    .dat_o     (dat_o),
    .dat_i     (dat_i),
    .sel_o     (sel_o),
    .cyc_o     (cyc_o),
    .stb_o     (stb_o),
    .we_o      (we_o),
    .ack_i     (ack_i),
    .s_dat     (s_dat),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .init_done (init_done),
    .busy      (busy)
  );

  // Slave model: ack after ack_dly wait cycles, LSR value from a scripted sequence.
  assign ack_i = stb_o && (wcnt >= ack_dly);

  always_comb begin
    lsr_byte = lsr_default;
    if ((rd_cnt - lsr_start) < lsr_len) lsr_byte = lsr_seq[rd_cnt - lsr_start];
  end
  assign dat_i = {4{lsr_byte}};

  always @(posedge clk) begin
    if (cyc_o && stb_o && ack_i) begin
      log_adr.push_back(adr_o);
      log_dat.push_back(dat_o);
      log_sel.push_back(sel_o);
      log_we.push_back(we_o);
      if (we_o) wr_cnt <= wr_cnt + 1;
      else      rd_cnt <= rd_cnt + 1;
    end
    if (!stb_o || ack_i) wcnt <= 0;
    else                 wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_init();
    @(negedge clk);
    rstn_i  = 1'b0;
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cyc",  32'(cyc_o), 32'd0);
    chk("rst_stb",  32'(stb_o), 32'd0);
    chk("rst_adr",  adr_o, 32'd0);
    chk("rst_dat",  dat_o, 32'd0);
    chk("rst_sel",  32'(sel_o), 32'd0);
    chk("rst_we",   32'(we_o), 32'd0);
    chk("rst_srdy", 32'(s_ready), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rstn_i = 1'b1;
    repeat (9) @(negedge clk);
    chk("init_done_c9",  32'(init_done), 32'd0);
    chk("init_srdy_c9",  32'(s_ready), 32'd0);
    @(negedge clk);
    chk("init_done_c10", 32'(init_done), 32'd1);
    chk("init_cyc_c10",  32'(cyc_o), 32'd0);
  endtask

  task automatic send(input logic [7:0] b);
    bit got;
    got     = 1'b0;
    s_dat   = b;
    s_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (s_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("hs_timeout", 32'(got), 32'd1);
    if (got) begin
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
      chk("lat_stb", 32'(stb_o), 32'd1);
      chk("lat_we",  32'(we_o), 32'd1);
      chk("lat_dat", dat_o, {4{b}});
    end else begin
      s_valid = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] exp_adr [5];
    logic [31:0] exp_dat [5];
    logic [3:0]  exp_sel [5];
    int          m0, r0, w0, cnt;
    bit          got;

    exp_adr = '{BASE + 32'd3, BASE + 32'd0, BASE + 32'd1, BASE + 32'd3, BASE + 32'd2};
    exp_dat = '{32'h8383_8383, 32'h3434_3434, 32'h1212_1212, 32'h0303_0303, 32'h0707_0707};
    exp_sel = '{4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0100};
    lsr_seq = '{8'h00, 8'h00, 8'h00, 8'h20};

    // Init sequence after reset release
    reset_init();
    chk("init_n_acc", 32'(log_adr.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < log_adr.size()) begin
        chk($sformatf("init%0d_adr", i), log_adr[i], exp_adr[i]);
        chk($sformatf("init%0d_dat", i), log_dat[i], exp_dat[i]);
        chk($sformatf("init%0d_sel", i), 32'(log_sel[i]), 32'(exp_sel[i]));
        chk($sformatf("init%0d_we", i),  32'(log_we[i]), 32'd1);
      end
    end

    // One byte, LSR poll returns 0x60
    m0 = log_adr.size();
    lsr_default = 8'h60;
    send(8'hA5);
    repeat (3) @(negedge clk);
    chk("b1_n_acc", 32'(log_adr.size() - m0), 32'd2);
    if (log_adr.size() >= m0 + 2) begin
      chk("b1_rd_we",  32'(log_we[m0]), 32'd0);
      chk("b1_rd_adr", log_adr[m0], BASE + 32'd5);
      chk("b1_rd_sel", 32'(log_sel[m0]), 32'b0010);
      chk("b1_wr_we",  32'(log_we[m0+1]), 32'd1);
      chk("b1_wr_adr", log_adr[m0+1], BASE);
      chk("b1_wr_dat", log_dat[m0+1], 32'hA5A5_A5A5);
      chk("b1_wr_sel", 32'(log_sel[m0+1]), 32'b0001);
    end

    // 20 back-to-back bytes from fresh credit, LSR always THRE
    reset_init();
    lsr_default = 8'h20;
    r0 = rd_cnt;
    w0 = wr_cnt;
    for (int i = 0; i < 20; i++) send(8'h40 + 8'(i));
    repeat (4) @(negedge clk);
    chk("b20_reads",  32'(rd_cnt - r0), 32'(EXP_RD20));
    chk("b20_writes", 32'(wr_cnt - w0), 32'd20);
    chk("b20_last",   log_dat[log_dat.size()-1], 32'h5353_5353);

    // Reset during the THR write access
    send(8'h5A);
    rstn_i = 1'b0;
    #1;
    chk("midrst_cyc",  32'(cyc_o), 32'd0);
    chk("midrst_stb",  32'(stb_o), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    m0 = log_adr.size();
    reset_init();
    chk("midrst_n_acc", 32'(log_adr.size() - m0), 32'd5);
    if (log_adr.size() > m0) begin
      chk("midrst_first_adr", log_adr[m0], BASE + 32'd3);
      chk("midrst_first_dat", log_dat[m0], 32'h8383_8383);
    end
    repeat (5) @(negedge clk);
    cnt = 0;
    for (int i = m0; i < log_dat.size(); i++) if (log_dat[i] == 32'h5A5A_5A5A) cnt++;
    chk("midrst_no_5a", 32'(cnt), 32'd0);

    // LSR not empty three times, then THRE
    r0 = rd_cnt;
    w0 = wr_cnt;
    lsr_start = rd_cnt;
    lsr_len   = 4;
    s_dat     = 8'h3C;
    s_valid   = 1'b1;
    got       = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (s_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("poll_ready",       32'(got), 32'd1);
    chk("poll_reads_at_rdy", 32'(rd_cnt - r0), 32'd4);
    chk("poll_no_wr_early",  32'(wr_cnt - w0), 32'd0);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("poll_writes", 32'(wr_cnt - w0), 32'd1);
    chk("poll_reads",  32'(rd_cnt - r0), 32'd4);
    chk("poll_wr_dat", log_dat[log_dat.size()-1], 32'h3C3C_3C3C);
    lsr_len = 0;

    // Delayed ack: write held stable for 6 cycles, then an idle cycle
    ack_dly = 5;
    send(8'h77);
    for (int c = 1; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("dly_c%0d_stb", c), 32'(stb_o), 32'd1);
      chk($sformatf("dly_c%0d_cyc", c), 32'(cyc_o), 32'd1);
      chk($sformatf("dly_c%0d_adr", c), adr_o, BASE);
      chk($sformatf("dly_c%0d_dat", c), dat_o, 32'h7777_7777);
      chk($sformatf("dly_c%0d_sel", c), 32'(sel_o), 32'b0001);
      chk($sformatf("dly_c%0d_we", c),  32'(we_o), 32'd1);
    end
    @(negedge clk);
    chk("dly_idle_cyc",  32'(cyc_o), 32'd0);
    chk("dly_idle_busy", 32'(busy), 32'd0);
    chk("dly_last_dat",  log_dat[log_dat.size()-1], 32'h7777_7777);
    ack_dly = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
